// File: rtl/tstate_sequencer.sv
// T-state sequencer: turns the free-running clock into a prescaled CPU micro-step
// enable and T-state count, with free-run, single-step and HLT-driven halt.
module tstate_sequencer #(
    parameter int NUM_T     = 6,
    parameter int T_WIDTH   = 3,
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 step,
    input  logic                 halt,
    input  logic                 resume,
    input  logic                 short_cycle,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick,
    output logic [T_WIDTH-1:0]   tstate,
    output logic [NUM_T-1:0]     tstate_onehot,
    output logic                 cycle_start,
    output logic                 busy,
    output logic                 halted,
    output logic                 step_done
);

    typedef enum logic [1:0] {IDLE, RUN, STEP, HALT} state_t;

    state_t               state;
    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] div_reg;
    logic                 halt_lat;
    logic                 step_q;
    logic                 last_t;
    logic                 boundary;
    logic [T_WIDTH-1:0]   tstate_nxt;

    assign busy        = (state == RUN) || (state == STEP);
    assign halted      = (state == HALT);
    assign tick        = busy && (cnt == div_reg);
    assign cycle_start = tick && (tstate == '0);
    assign last_t      = (tstate == T_WIDTH'(NUM_T - 1));
    // boundary is only meaningful when qualified by tick
    assign boundary    = tick && (last_t || short_cycle);
    assign tstate_nxt  = (last_t || short_cycle) ? '0 : tstate + T_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            tstate        <= '0;
            tstate_onehot <= NUM_T'(1);
            cnt           <= '0;
            div_reg       <= '0;
            halt_lat      <= 1'b0;
            step_q        <= 1'b0;
            step_done     <= 1'b0;
        end else begin
            step_q    <= step;
            step_done <= 1'b0;

            if (tick) begin
                tstate        <= tstate_nxt;
                tstate_onehot <= NUM_T'(1) << tstate_nxt;
                cnt           <= '0;
                div_reg       <= div;
            end else if (busy) begin
                cnt <= cnt + DIV_WIDTH'(1);
            end

            if (busy && halt)
                halt_lat <= 1'b1;

            case (state)
                IDLE: begin
                    if (run || (step && !step_q)) begin
                        state   <= run ? RUN : STEP;
                        cnt     <= '0;
                        div_reg <= div;
                    end
                end
                RUN: begin
                    // run low mid-instruction lets the instruction finish
                    if (boundary) begin
                        if (halt_lat || halt) begin
                            state    <= HALT;
                            halt_lat <= 1'b0;
                        end else if (!run) begin
                            state <= IDLE;
                        end
                    end
                end
                STEP: begin
                    if (boundary) begin
                        step_done <= 1'b1;
                        if (halt_lat || halt) begin
                            state    <= HALT;
                            halt_lat <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                HALT: begin
                    if (resume)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tstate_sequencer.sv
// Scoreboard bench for tstate_sequencer: scenarios queue per-cycle expected outputs,
// a negedge monitor pops and compares them as the cycles go by.
module tb_tstate_sequencer;

    logic       clk = 1'b0;
    logic       rst, run, step, halt, resume, short_cycle;
    logic [7:0] div;
    logic       tick, cycle_start, busy, halted, step_done;
    logic [2:0] tstate;
    logic [5:0] tstate_onehot;

    tstate_sequencer #(.NUM_T(6), .T_WIDTH(3), .DIV_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .run(run), .step(step), .halt(halt),
        .resume(resume), .short_cycle(short_cycle), .div(div),
        .tick(tick), .tstate(tstate), .tstate_onehot(tstate_onehot),
        .cycle_start(cycle_start), .busy(busy), .halted(halted),
        .step_done(step_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       tag;
        logic [13:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [13:0] got, input logic [13:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (tick,ts,onehot,cs,busy,halted,done)", tag, got, exp);
        end
    endtask

    // expected output vector, in the same field order as the monitor's observation
    function automatic logic [13:0] ev(input bit tk, input int ts, input bit bs,
                                       input bit hl, input bit sd);
        logic [5:0] oh;
        oh = 6'b1 << ts;
        return {tk, 3'(ts), oh, (tk && ts == 0), bs, hl, sd};
    endfunction

    task automatic push(input int c, input string tag, input logic [13:0] v);
        exp_t e;
        e.cyc = c;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            chk(e.tag, {tick, tstate, tstate_onehot, cycle_start, busy, halted, step_done}, e.v);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    int c0;

    initial begin
        rst = 1'b1; run = 1'b0; step = 1'b0; halt = 1'b0;
        resume = 1'b0; short_cycle = 1'b0; div = 8'd0;

        // reset state
        repeat (2) @(negedge clk);
        push(cyc + 1, "rst0", ev(0, 0, 0, 0, 0));
        push(cyc + 2, "rst1", ev(0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // free run div=0; run dropped at T1 of 2nd instr; step edge during RUN ignored
        c0 = cyc; run = 1'b1; div = 8'd0;
        for (int k = 1; k <= 12; k++) push(c0 + k, $sformatf("run.c%0d", k), ev(1, (k - 1) % 6, 1, 0, 0));
        push(c0 + 13, "run.idle0", ev(0, 0, 0, 0, 0));
        push(c0 + 14, "run.idle1", ev(0, 0, 0, 0, 0));
        repeat (8) @(negedge clk); run = 1'b0;
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
        repeat (5) @(negedge clk);

        // single step with div=2
        c0 = cyc; div = 8'd2; step = 1'b1;
        for (int k = 1; k <= 18; k++) push(c0 + k, $sformatf("step.c%0d", k), ev(k % 3 == 0, (k - 1) / 3, 1, 0, 0));
        push(c0 + 19, "step.done", ev(0, 0, 0, 0, 1));
        push(c0 + 20, "step.after", ev(0, 0, 0, 0, 0));
        @(negedge clk); step = 1'b0;
        repeat (20) @(negedge clk);

        // short cycle at T3 skips T4/T5
        c0 = cyc; div = 8'd0; run = 1'b1;
        for (int k = 1; k <= 4; k++) push(c0 + k, $sformatf("short.c%0d", k), ev(1, k - 1, 1, 0, 0));
        for (int k = 5; k <= 10; k++) push(c0 + k, $sformatf("short.c%0d", k), ev(1, k - 5, 1, 0, 0));
        push(c0 + 11, "short.idle", ev(0, 0, 0, 0, 0));
        repeat (4) @(negedge clk); short_cycle = 1'b1;
        @(negedge clk); short_cycle = 1'b0; run = 1'b0;
        repeat (7) @(negedge clk);

        // halt at T2, finish instruction, HALT, resume with run=1, rerun at div=1
        c0 = cyc; div = 8'd0; run = 1'b1;
        for (int k = 1; k <= 6; k++) push(c0 + k, $sformatf("halt.c%0d", k), ev(1, k - 1, 1, 0, 0));
        for (int k = 7; k <= 9; k++) push(c0 + k, $sformatf("halt.hlt%0d", k), ev(0, 0, 0, 1, 0));
        push(c0 + 10, "halt.idle", ev(0, 0, 0, 0, 0));
        for (int k = 11; k <= 22; k++) push(c0 + k, $sformatf("halt.rerun%0d", k), ev((k - 11) % 2 == 1, (k - 11) / 2, 1, 0, 0));
        push(c0 + 23, "halt.end", ev(0, 0, 0, 0, 0));
        repeat (3) @(negedge clk); halt = 1'b1;
        @(negedge clk); halt = 1'b0;
        repeat (5) @(negedge clk); resume = 1'b1; div = 8'd1;
        @(negedge clk); resume = 1'b0;
        repeat (4) @(negedge clk); run = 1'b0;
        repeat (10) @(negedge clk);

        // div=3 run, reset at T4 mid-count with step held through reset
        c0 = cyc; div = 8'd3; run = 1'b1;
        for (int k = 1; k <= 18; k++) push(c0 + k, $sformatf("mrst.c%0d", k), ev(k % 4 == 0, (k - 1) / 4, 1, 0, 0));
        push(c0 + 19, "mrst.reset", ev(0, 0, 0, 0, 0));
        for (int k = 20; k <= 25; k++) push(c0 + k, $sformatf("mrst.step%0d", k), ev(1, k - 20, 1, 0, 0));
        push(c0 + 26, "mrst.done", ev(0, 0, 0, 0, 1));
        push(c0 + 27, "mrst.held", ev(0, 0, 0, 0, 0));
        push(c0 + 28, "mrst.held2", ev(0, 0, 0, 0, 0));
        repeat (17) @(negedge clk); step = 1'b1;
        @(negedge clk); rst = 1'b1; run = 1'b0; div = 8'd0;
        @(negedge clk); rst = 1'b0;
        repeat (8) @(negedge clk); step = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
        chk("drain", 14'(sb.size()), 14'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
